// File: rtl/weight_loader_pkg.sv
// Shared types and sizing helpers for the weight loader and its idle timer.
package weight_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int bytes_per_word(input int dw);
        return dw / BYTE_W;
    endfunction

    // Counter/address width for n distinct values, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_loader_idle_timer.sv
// Idle-cycle counter: clear dominates enable; tc_o flags TIMEOUT-1 idle cycles seen.
module idle_timer
    import weight_loader_pkg::*;
#(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign tc_o = 1'b0;
        end else begin : g_on
            localparam int CW = addr_width(TIMEOUT);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (en_i) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign tc_o = (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/weight_loader.sv
// Loads the weight memory from a byte stream: MSB-first words to sequential
// addresses, then verifies a trailing XOR checksum byte.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int N_WEIGHT   = 256,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [7:0]                          byte_in,
    input  logic                                byte_valid,
    output logic                                byte_ready,
    output logic                                wen,
    output logic [addr_width(N_WEIGHT)-1:0]     wadd,
    output logic [DATA_WIDTH-1:0]               win,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int AW  = addr_width(N_WEIGHT);
    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int BCW = addr_width(BPW);

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            xor_q, xor_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  wen_q, wen_d;
    logic [AW-1:0]         wadd_q, wadd_d;
    logic [DATA_WIDTH-1:0] win_q, win_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic xfer, listening, timer_tc, timed_out;

    assign xfer      = byte_valid & byte_ready_q;
    assign listening = (state_q == ST_RECV) || (state_q == ST_CHECK);
    assign timed_out = listening & ~xfer & timer_tc;

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~listening | xfer),
        .en_i  (listening),
        .tc_o  (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        xor_d   = xor_q;
        wen_d   = 1'b0;
        wadd_d  = wadd_q;
        win_d   = win_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RECV;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    bcnt_d  = '0;
                    xor_d   = '0;
                end
            end
            ST_RECV: begin
                if (xfer) begin
                    word_d = (word_q << 8) | DATA_WIDTH'(byte_in);
                    xor_d  = xor_q ^ byte_in;
                    if (bcnt_q == BCW'(BPW - 1)) begin
                        // Launch the write now so wen is high in the cycle right after the last byte.
                        bcnt_d  = '0;
                        state_d = ST_WRITE;
                        wen_d   = 1'b1;
                        wadd_d  = addr_q;
                        win_d   = word_d;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (addr_q == AW'(N_WEIGHT - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = (byte_in != xor_q);
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
        busy_d       = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            bcnt_q       <= '0;
            word_q       <= '0;
            xor_q        <= '0;
            byte_ready_q <= 1'b0;
            wen_q        <= 1'b0;
            wadd_q       <= '0;
            win_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            xor_q        <= xor_d;
            byte_ready_q <= byte_ready_d;
            wen_q        <= wen_d;
            wadd_q       <= wadd_d;
            win_q        <= win_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wen        = wen_q;
    assign wadd       = wadd_q;
    assign win        = win_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: directed byte streams, expected writes
// queued at stimulus time and checked by an independent write monitor.
module tb_weight_loader;

    localparam int NW = 4;
    localparam int DW = 16;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wen;
    logic [1:0]  wadd;
    logic [15:0] win;
    logic        busy;
    logic        done;
    logic        err;

    weight_loader #(.N_WEIGHT(NW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wen        (wen),
        .wadd       (wadd),
        .win        (win),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t sb[$];

    logic [7:0]  stream [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [15:0] words  [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Write monitor: every wen cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wen) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %h@%0d required no write", win, wadd);
            end else begin
                wr_t e;
                e = sb.pop_front();
                $display("write %h@%0d (expected %h@%0d)", win, wadd, e.d, e.a);
                check("wadd", 32'(wadd), 32'(e.a));
                check("win", 32'(win), 32'(e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept: byte %h byte_ready=%b required 1", b, byte_ready);
        end
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy=%b required 0 within %0d cycles", busy, budget);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) sb.push_back('{a: 2'(i), d: words[i]});
    endtask

    // mode 0: one-cycle gaps, 1: valid held high, 2: random gaps, 3: start pulsed mid-load
    task automatic load(input logic [7:0] csum, input int mode);
        int gap;
        push_words(NW);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (mode == 1) gap = 0;
            else if (mode == 2) gap = int'($urandom_range(0, 5));
            else gap = 1;
            send_byte(stream[i], gap);
            if (mode == 3 && i == 2) begin
                pulse_start();
                check("busy_after_restart", 32'(busy), 32'd1);
            end
        end
        send_byte(csum, 1);
        byte_valid = 1'b0;
        wait_idle(50);
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
        @(negedge clk);
        $display("%s: done=%b err=%b busy=%b", tag, done, err, busy);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_writes_pending"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_wen"}, 32'(wen), 32'd0);
        check({tag, "_wadd"}, 32'(wadd), 32'd0);
        check({tag, "_win"}, 32'(win), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. nominal
        load(8'h00, 0);
        check_end("nominal", 1'b1, 1'b0);

        // 2. bad checksum
        load(8'h01, 0);
        check_end("bad_csum", 1'b1, 1'b1);

        // 3a. valid held high through WRITE cycles
        load(8'h00, 1);
        check_end("continuous", 1'b1, 1'b0);

        // 3b. random gaps
        load(8'h00, 2);
        check_end("gaps", 1'b1, 1'b0);

        // 4. timeout: exactly TO idle cycles after the last accepted byte
        push_words(1);
        pulse_start();
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        send_byte(8'h56, 0);
        byte_valid = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        check("busy_before_timeout", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check_end("timeout", 1'b0, 1'b1);

        // 5. reset mid-load, with start coinciding with reset
        push_words(2);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i], 1);
        rst   = 1'b1;
        start = 1'b1;
        #1;
        check_zero("midload_rst");
        check("midload_writes_pending", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_beats_start_busy", 32'(busy), 32'd0);
        load(8'h00, 0);
        check_end("after_rst", 1'b1, 1'b0);

        // 6. start while busy
        load(8'h00, 3);
        check_end("start_busy", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Fills the weight memory through its write port (wen/wadd/win) from a byte stream, e.g. the UART receiver on the board.
- Assembles DATA_WIDTH-bit words MSB byte first and writes them to sequential addresses 0..N_WEIGHT-1.
- Checks a trailing XOR checksum byte and reports done/err; aborts on inter-byte timeout.
- Sits between the byte source and the weight memory; the inference datapath reads the memory afterwards.

Parameters:
- N_WEIGHT, 256, number of words to load; wadd width is $clog2(N_WEIGHT).
- DATA_WIDTH, 16, word width; must be a multiple of 8, BYTES_PER_WORD = DATA_WIDTH/8.
- TIMEOUT, 1000000, max clk cycles without an accepted byte while loading; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a load; ignored while busy
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready
- wen  output  1  memory write enable, one-cycle pulse per word
- wadd  output  $clog2(N_WEIGHT)  memory write address
- win  output  DATA_WIDTH  memory write data
- busy  output  1  load in progress
- done  output  1  load completed; held until next accepted start
- err  output  1  checksum mismatch or timeout; held until next accepted start

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; addr, byte count, word shift register, XOR accumulator and timer cleared; partial data discarded.
- All outputs are registered.
- IDLE: byte_ready=0, busy=0. start=1 -> RECV; clear done, err, addr, byte count, XOR and timer.
- RECV: busy=1, byte_ready=1.
  - On transfer: word <= {word[DATA_WIDTH-9:0], byte_in}; xor <= xor ^ byte_in; byte count +1; timer cleared.
  - After BYTES_PER_WORD transfers -> WRITE.
- WRITE: exactly one cycle; byte_ready=0, wen=1, wadd=addr, win=assembled word.
  - Bytes presented during WRITE are not consumed.
  - If addr == N_WEIGHT-1 -> CHECK, else addr+1 and -> RECV.
  - Latency: final byte of a word accepted at edge k -> wen high during the cycle after edge k.
- CHECK: byte_ready=1; on transfer compare byte_in with xor -> DONE; err=1 if they differ.
- DONE: busy=0, done=1 -> IDLE on the next cycle. done and err stay held in IDLE.
- Timeout: in RECV/CHECK the timer increments each cycle without a transfer.
  - When it reaches TIMEOUT-1 with no transfer -> IDLE with err=1, done=0.
  - Words already written stay in memory.
- wen is 0 in every state except WRITE. wadd/win hold their last values otherwise.
- start while busy: ignored; no effect on counters or flags.
- start in the same cycle as rst: rst wins.
- Checksum covers every data byte (N_WEIGHT*BYTES_PER_WORD bytes) but not the checksum byte itself.

Decomposition:
- Shared package:
  - state encoding (IDLE, RECV, WRITE, CHECK, DONE)
  - BYTES_PER_WORD and address-width helper constants
- Sub-module idle_timer: counter with clear/enable and a terminal-count flag, parameterised by TIMEOUT; ties its output low when TIMEOUT=0.
- FSM, word assembler and XOR accumulator stay in weight_loader.

Test Plan (N_WEIGHT=4, DATA_WIDTH=16, TIMEOUT=16 unless stated):
1. Nominal load.
   - Stimulus: start, bytes 12 34 56 78 9A BC DE F0, checksum 00.
   - Required: writes 0x1234@0, 0x5678@1, 0x9ABC@2, 0xDEF0@3, each a single-cycle wen; done=1, err=0, busy=0.
2. Bad checksum.
   - Stimulus: same data, checksum 01.
   - Required: same four writes; done=1, err=1.
3. Backpressure and gaps.
   - Stimulus: byte_valid held high continuously, plus random 0-5 cycle gaps.
   - Required: no byte lost or duplicated during WRITE cycles; same writes as scenario 1.
4. Timeout.
   - Stimulus: start, send 12 34 56, then idle 16 cycles.
   - Required: exactly one write (0x1234@0); then err=1, done=0, busy=0, byte_ready=0.
5. Reset mid-load.
   - Stimulus: assert rst after 5 bytes.
   - Required: all outputs 0 immediately; a following full load of scenario 1 writes correctly from addr 0 with no stale byte.
6. start while busy.
   - Stimulus: pulse start after 3 bytes.
   - Required: load continues unaffected; results identical to scenario 1.
